// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
// Holds reset PC, bubble encoding, fetch FSM and redirect-source enums.
package mips_pipe_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        RUN    = 1'b0,
        REFILL = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        SRC_SEQ  = 2'd0,
        SRC_JUMP = 2'd1,
        SRC_BNE  = 2'd2,
        SRC_JR   = 2'd3
    } redirect_src_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter, increments by 0..2 per clock.
// Sticks at all-ones; cleared by asynchronous reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W:0] sum;

    assign sum = {1'b0, count} + {{(CNT_W - 1){1'b0}}, inc};

    // Accumulate, clamping at all-ones when the add carries out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (sum[CNT_W]) begin
            count <= '1;
        end else begin
            count <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/if_fetch_redirect.sv
// Fetch stage: PC register, IF/ID register and redirect/refill FSM.
// Optional statistics counters are built when FLUSH_STATS_EN is defined.
module if_fetch_redirect
    import mips_pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_PC  = mips_pipe_pkg::RESET_PC,
    parameter logic [DATA_W-1:0] NOP_INSTR = mips_pipe_pkg::NOP_INSTR,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              IF_flush,
    input  logic              ID_flush,
    input  logic              jump,
    input  logic              bne,
    input  logic              jr,
    input  logic [DATA_W-1:0] jump_target,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [DATA_W-1:0] jr_target,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [DATA_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic              redirect_busy,
    output logic [CNT_W-1:0]  flush_events,
    output logic [CNT_W-1:0]  squashed_instrs
);

    redirect_src_e     src;
    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] next_pc;

    assign pc_plus4 = pc + DATA_W'(4);

    // Pick redirect source; EX-stage jr/bne are older than an ID jump.
    always_comb begin
        src = SRC_SEQ;
        if (IF_flush) begin
            if (jr) begin
                src = SRC_JR;
            end else if (bne) begin
                src = SRC_BNE;
            end else if (jump) begin
                src = SRC_JUMP;
            end
        end
    end

    // Next fetch address: flush beats stall; a bare flush steps sequentially.
    always_comb begin
        next_pc = pc_plus4;
        if (IF_flush) begin
            case (src)
                SRC_JR:   next_pc = jr_target;
                SRC_BNE:  next_pc = branch_target;
                SRC_JUMP: next_pc = jump_target;
                default:  next_pc = pc_plus4;
            endcase
        end else if (stall) begin
            next_pc = pc;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // IF/ID register: bubble on flush, hold on stall, else capture fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (IF_flush) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: REFILL lasts one cycle unless re-flushed or stalled.
    always_comb begin
        state_d       = state_q;
        redirect_busy = 1'b0;
        unique case (state_q)
            RUN: begin
                if (IF_flush) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                redirect_busy = 1'b1;
                if (!IF_flush && !stall) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

`ifdef FLUSH_STATS_EN
    logic [1:0] flush_inc;
    logic [1:0] squash_inc;

    // A flush always drops the fetch; an ID flush also drops a live IF/ID.
    always_comb begin
        flush_inc  = {1'b0, IF_flush};
        squash_inc = 2'd0;
        if (IF_flush) begin
            squash_inc = (ID_flush && if_id_valid) ? 2'd2 : 2'd1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_events)
    );

    sat_counter #(.CNT_W(CNT_W)) u_squash_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (squash_inc),
        .count (squashed_instrs)
    );
`else
    logic unused_id_flush;

    assign unused_id_flush = ID_flush;
    assign flush_events    = '0;
    assign squashed_instrs = '0;
`endif

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Directed bench for if_fetch_redirect with immediate-assertion checks.
// Counter expectations follow FLUSH_STATS_EN when it is defined.
module tb_if_fetch_redirect;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        IF_flush;
    logic        ID_flush;
    logic        jump;
    logic        bne;
    logic        jr;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] jr_target;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        redirect_busy;
    logic [15:0] flush_events;
    logic [15:0] squashed_instrs;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] I0  = 32'h2008_0005;
    localparam logic [31:0] I40 = 32'h1111_2222;

    always #5 clk = ~clk;

    if_fetch_redirect dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .IF_flush        (IF_flush),
        .ID_flush        (ID_flush),
        .jump            (jump),
        .bne             (bne),
        .jr              (jr),
        .jump_target     (jump_target),
        .branch_target   (branch_target),
        .jr_target       (jr_target),
        .imem_rdata      (imem_rdata),
        .pc              (pc),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .redirect_busy   (redirect_busy),
        .flush_events    (flush_events),
        .squashed_instrs (squashed_instrs)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ifid(input string tag, input logic [31:0] ins,
                        input logic [31:0] p4, input logic v);
        chk({tag, "_instr"}, if_id_instr, ins);
        chk({tag, "_pc4"}, if_id_pc4, p4);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
    endtask

    task automatic stats(input string tag, input int fe, input int sq);
`ifdef FLUSH_STATS_EN
        chk({tag, "_fe"}, {16'd0, flush_events}, fe);
        chk({tag, "_sq"}, {16'd0, squashed_instrs}, sq);
`else
        chk({tag, "_fe"}, {16'd0, flush_events}, 32'd0);
        chk({tag, "_sq"}, {16'd0, squashed_instrs}, 32'd0);
        if (fe < 0 || sq < 0) $display("unexpected negative count");
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall    = 1'b0;
        IF_flush = 1'b0;
        ID_flush = 1'b0;
        jump     = 1'b0;
        bne      = 1'b0;
        jr       = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        clr();
        jump_target   = '0;
        branch_target = '0;
        jr_target     = '0;
        imem_rdata    = I0;
        #2;
        chk("rst_pc", pc, 32'h0);
        ifid("rst", NOP, 32'h0, 1'b0);
        chk("rst_busy", {31'd0, redirect_busy}, 32'd0);
        stats("rst", 0, 0);

        tick();
        reset = 1'b0;
        chk("run0_pc", pc, 32'h0);
        tick();
        chk("run1_pc", pc, 32'h4);
        ifid("run1", I0, 32'h4, 1'b1);
        tick();
        chk("run2_pc", pc, 32'h8);
        ifid("run2", I0, 32'h8, 1'b1);

        stall = 1'b1;
        imem_rdata = 32'hAAAA_5555;
        tick();
        chk("stall1_pc", pc, 32'h8);
        ifid("stall1", I0, 32'h8, 1'b1);
        tick();
        chk("stall2_pc", pc, 32'h8);
        ifid("stall2", I0, 32'h8, 1'b1);
        stall = 1'b0;
        imem_rdata = I0;
        tick();
        chk("rel_pc", pc, 32'hC);
        ifid("rel", I0, 32'hC, 1'b1);
        tick();
        chk("run3_pc", pc, 32'h10);

        IF_flush = 1'b1;
        jump = 1'b1;
        jump_target = 32'h40;
        tick();
        chk("jmp_pc", pc, 32'h40);
        ifid("jmp", NOP, 32'h0, 1'b0);
        chk("jmp_busy", {31'd0, redirect_busy}, 32'd1);
        stats("jmp", 1, 1);
        clr();
        imem_rdata = I40;
        tick();
        chk("tgt_pc", pc, 32'h44);
        ifid("tgt", I40, 32'h44, 1'b1);
        chk("tgt_busy", {31'd0, redirect_busy}, 32'd0);

        IF_flush = 1'b1;
        ID_flush = 1'b1;
        bne = 1'b1;
        jump = 1'b1;
        stall = 1'b1;
        branch_target = 32'h80;
        jump_target = 32'h40;
        tick();
        chk("bne_pc", pc, 32'h80);
        ifid("bne", NOP, 32'h0, 1'b0);
        chk("bne_busy", {31'd0, redirect_busy}, 32'd1);
        stats("bne", 2, 3);
        clr();

        IF_flush = 1'b1;
        jr = 1'b1;
        jr_target = 32'h100;
        tick();
        chk("b2b1_pc", pc, 32'h100);
        chk("b2b1_busy", {31'd0, redirect_busy}, 32'd1);
        clr();
        IF_flush = 1'b1;
        jump = 1'b1;
        jump_target = 32'h200;
        tick();
        chk("b2b2_pc", pc, 32'h200);
        chk("b2b2_busy", {31'd0, redirect_busy}, 32'd1);
        ifid("b2b2", NOP, 32'h0, 1'b0);
        clr();
        stall = 1'b1;
        tick();
        chk("refstall_pc", pc, 32'h200);
        chk("refstall_busy", {31'd0, redirect_busy}, 32'd1);
        stats("refstall", 4, 5);

        reset = 1'b1;
        #2;
        chk("arst_pc", pc, 32'h0);
        ifid("arst", NOP, 32'h0, 1'b0);
        chk("arst_busy", {31'd0, redirect_busy}, 32'd0);
        stats("arst", 0, 0);
        tick();
        reset = 1'b0;
        clr();
        imem_rdata = I0;
        tick();
        chk("post_pc", pc, 32'h4);
        ifid("post", I0, 32'h4, 1'b1);

        IF_flush = 1'b1;
        tick();
        chk("bare_pc", pc, 32'h8);
        ifid("bare", NOP, 32'h0, 1'b0);
        clr();
        tick();
        chk("bare_busy", {31'd0, redirect_busy}, 32'd0);
        chk("bare2_pc", pc, 32'hC);

        IF_flush = 1'b1;
        jr = 1'b1;
        bne = 1'b1;
        jr_target = 32'hFFFF_FFFC;
        branch_target = 32'h300;
        tick();
        chk("jrwin_pc", pc, 32'hFFFF_FFFC);
        clr();
        tick();
        chk("wrap_pc", pc, 32'h0);
        ifid("wrap", I0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
